// File: rtl/regfile_writeback_pkg.sv
// Shared register-file constants and the architectural register index type.
package regfile_writeback_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/stage_reg_pkg.sv
// Pipeline stage register types passed between execute and writeback.
package stage_reg_pkg;

    import regfile_writeback_pkg::*;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic            alu_result_ready;
        reg_idx_t        reg_wr_addr;
        logic            reg_wr_en;
    } EX_WB;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with source-busy and saturation stall logic.
module reg_scoreboard
    import regfile_writeback_pkg::reg_idx_t;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    input  reg_idx_t rs1_addr,
    input  reg_idx_t rs2_addr,
    input  logic     issue_valid,
    input  reg_idx_t issue_rd,
    input  logic     issue_wr_en,
    input  logic     retire_valid,
    input  reg_idx_t retire_addr,
    output logic     hazard_stall
);

    logic [1:0] pend_q [NUM_REGS];
    logic [1:0] pend_d [NUM_REGS];

    logic [1:0] rs1_cnt;
    logic [1:0] rs2_cnt;
    logic [1:0] rd_cnt;
    logic       rs1_busy;
    logic       rs2_busy;
    logic       rd_sat;
    logic       issue_req;
    logic       issue_accept;

    // Entry 0 is never looked up, so x0 always reports a zero count.
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_addr == reg_idx_t'(i)) rs1_cnt = pend_q[i];
            if (rs2_addr == reg_idx_t'(i)) rs2_cnt = pend_q[i];
            if (issue_rd == reg_idx_t'(i)) rd_cnt = pend_q[i];
        end
    end

    always_comb begin
        issue_req = issue_valid && issue_wr_en && (issue_rd != '0);
        // The last outstanding write resolving this cycle is covered by the bypass.
        rs1_busy  = (rs1_cnt != 2'd0) &&
                    !((rs1_cnt == 2'd1) && retire_valid && (retire_addr == rs1_addr));
        rs2_busy  = (rs2_cnt != 2'd0) &&
                    !((rs2_cnt == 2'd1) && retire_valid && (retire_addr == rs2_addr));
        rd_sat    = issue_valid && issue_wr_en && (rd_cnt == 2'd3) &&
                    !(retire_valid && (retire_addr == issue_rd));
        hazard_stall = reset_n && (rs1_busy || rs2_busy || rd_sat);
        issue_accept = issue_req && !hazard_stall;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = pend_q[i];
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issue_accept && (issue_rd == reg_idx_t'(i)) &&
                !(retire_valid && (retire_addr == reg_idx_t'(i)) && (pend_q[i] != 2'd0))) begin
                pend_d[i] = pend_q[i] + 2'd1;
            end else if (!(issue_accept && (issue_rd == reg_idx_t'(i))) &&
                         retire_valid && (retire_addr == reg_idx_t'(i)) &&
                         (pend_q[i] != 2'd0)) begin
                pend_d[i] = pend_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback register file with same-cycle bypass, retire counter and issue scoreboard.
module regfile_writeback
    import regfile_writeback_pkg::reg_idx_t;
    import stage_reg_pkg::EX_WB;
#(
    parameter int unsigned XLEN     = regfile_writeback_pkg::XLEN,
    parameter int unsigned NUM_REGS = regfile_writeback_pkg::NUM_REGS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  EX_WB            ex_wb_reg,
    input  reg_idx_t        rs1_addr,
    input  reg_idx_t        rs2_addr,
    output logic [XLEN-1:0] alu_reg_input_a,
    output logic [XLEN-1:0] alu_reg_input_b,
    input  logic            issue_valid,
    input  reg_idx_t        issue_rd,
    input  logic            issue_wr_en,
    output logic            hazard_stall,
    output logic [31:0]     retire_count
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [31:0]     retire_count_q;
    logic [XLEN-1:0] wb_data;
    reg_idx_t        wb_addr;
    logic            retire;
    logic [XLEN-1:0] arr_a;
    logic [XLEN-1:0] arr_b;

    assign wb_data = XLEN'(ex_wb_reg.alu_result);
    assign wb_addr = ex_wb_reg.reg_wr_addr;
    // Writes to x0 and anything presented during reset are not retires.
    assign retire  = reset_n && ex_wb_reg.alu_result_ready && ex_wb_reg.reg_wr_en &&
                     (wb_addr != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            retire_count_q <= '0;
        end else if (retire) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wb_addr == reg_idx_t'(i)) regs_q[i] <= wb_data;
            end
            retire_count_q <= retire_count_q + 32'd1;
        end
    end

    always_comb begin
        arr_a = '0;
        arr_b = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_addr == reg_idx_t'(i)) arr_a = regs_q[i];
            if (rs2_addr == reg_idx_t'(i)) arr_b = regs_q[i];
        end
        alu_reg_input_a = arr_a;
        alu_reg_input_b = arr_b;
        if (retire && (rs1_addr == wb_addr)) alu_reg_input_a = wb_data;
        if (retire && (rs2_addr == wb_addr)) alu_reg_input_b = wb_data;
    end

    assign retire_count = retire_count_q;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .reset_n      (reset_n),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_wr_en  (issue_wr_en),
        .retire_valid (retire),
        .retire_addr  (wb_addr),
        .hazard_stall (hazard_stall)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a behavioural model.
module tb_regfile_writeback;

    import regfile_writeback_pkg::*;
    import stage_reg_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    EX_WB        ex;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_wr_en;
    logic        stall;
    logic [31:0] rcount;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ex_wb_reg       (ex),
        .rs1_addr        (rs1),
        .rs2_addr        (rs2),
        .alu_reg_input_a (op_a),
        .alu_reg_input_b (op_b),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_wr_en     (issue_wr_en),
        .hazard_stall    (stall),
        .retire_count    (rcount)
    );

    // Behavioural model: architectural values, outstanding writes per register, retire total.
    logic [31:0] m_regs [32];
    int          m_pend [32];
    logic [31:0] m_count;
    logic        m_retire;
    logic        m_stall;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mread(logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_retire && a == ex.reg_wr_addr) return ex.alu_result;
        return m_regs[a];
    endfunction

    function automatic logic mbusy(logic [4:0] a);
        if (a == 5'd0 || m_pend[a] == 0) return 1'b0;
        return !(m_pend[a] == 1 && m_retire && ex.reg_wr_addr == a);
    endfunction

    task automatic set_in(input logic rst, input logic rdy, input logic en, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                          input logic iv, input logic [4:0] ird, input logic iwe);
        reset_n             = rst;
        ex.alu_result_ready = rdy;
        ex.reg_wr_en        = en;
        ex.reg_wr_addr      = wa;
        ex.alu_result       = wd;
        rs1                 = r1;
        rs2                 = r2;
        issue_valid         = iv;
        issue_rd            = ird;
        issue_wr_en         = iwe;
    endtask

    // Compare all outputs against the model for the inputs currently applied.
    task automatic eval();
        logic [31:0] ea;
        logic [31:0] eb;
        #1;
        m_retire = reset_n && ex.alu_result_ready && ex.reg_wr_en && ex.reg_wr_addr != 5'd0;
        ea       = mread(rs1);
        eb       = mread(rs2);
        m_stall  = reset_n && (mbusy(rs1) || mbusy(rs2) ||
                   (issue_valid && issue_wr_en && m_pend[issue_rd] == 3 &&
                    !(m_retire && ex.reg_wr_addr == issue_rd)));
        check("model_op_a", op_a, ea);
        check("model_op_b", op_b, eb);
        check("model_stall", 32'(stall), 32'(m_stall));
        check("model_retire_count", rcount, m_count);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 0;
            end
            m_count = 32'd0;
        end else begin
            if (m_retire) begin
                m_regs[ex.reg_wr_addr] = ex.alu_result;
                m_count = m_count + 32'd1;
                if (m_pend[ex.reg_wr_addr] > 0) m_pend[ex.reg_wr_addr]--;
            end
            if (issue_valid && issue_wr_en && issue_rd != 5'd0 && !m_stall) m_pend[issue_rd]++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, r1, r2, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
        m_count  = 32'd0;
        m_retire = 1'b0;
        m_stall  = 1'b0;
        @(negedge clk);

        // Retire and issue presented during reset are dropped.
        set_in(1'b0, 1'b1, 1'b1, 5'd9, 32'h1, 5'd9, 5'd0, 1'b1, 5'd9, 1'b1);
        eval();
        check("reset_op_a", op_a, 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        advance();
        idle(5'd9, 5'd9);
        eval();
        check("post_reset_op_a", op_a, 32'd0);
        check("post_reset_stall", 32'(stall), 32'd0);
        check("post_reset_count", rcount, 32'd0);
        advance();

        // Same-cycle bypass, then array read.
        set_in(1'b1, 1'b1, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        eval();
        check("bypass_a", op_a, 32'h1234_5678);
        advance();
        idle(5'd5, 5'd0);
        eval();
        check("array_a", op_a, 32'h1234_5678);
        advance();

        // Retire to x0 is discarded.
        set_in(1'b1, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        eval();
        check("x0_bypass_b", op_b, 32'd0);
        advance();
        idle(5'd0, 5'd0);
        eval();
        check("x0_read_b", op_b, 32'd0);
        check("x0_count", rcount, 32'd1);
        advance();

        // RAW hazard on x7 until it retires.
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1);
        eval();
        check("issue7_stall", 32'(stall), 32'd0);
        advance();
        for (int k = 0; k < 2; k++) begin
            idle(5'd7, 5'd0);
            eval();
            check("raw7_stall", 32'(stall), 32'd1);
            advance();
        end
        set_in(1'b1, 1'b1, 1'b1, 5'd7, 32'hA5A5_5A5A, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        eval();
        check("raw7_release_stall", 32'(stall), 32'd0);
        check("raw7_bypass_a", op_a, 32'hA5A5_5A5A);
        advance();

        // Saturation guard on x3.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1);
            eval();
            check("issue3_stall", 32'(stall), 32'd0);
            advance();
        end
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1);
        eval();
        check("sat3_stall", 32'(stall), 32'd1);
        advance();
        set_in(1'b1, 1'b1, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1);
        eval();
        check("sat3_retire_accept", 32'(stall), 32'd0);
        advance();
        set_in(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1);
        eval();
        check("sat3_still_full", 32'(stall), 32'd1);
        advance();

        // Mid-stream reset clears everything.
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd7, 1'b1, 5'd3, 1'b1);
        eval();
        check("midreset_stall", 32'(stall), 32'd0);
        advance();
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            eval();
            check("cleared_a", op_a, 32'd0);
            check("cleared_b", op_b, 32'd0);
            check("cleared_stall", 32'(stall), 32'd0);
            advance();
        end
        check("cleared_count", rcount, 32'd0);

        // Counter wrap.
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        m_count = 32'hFFFF_FFFF;
        set_in(1'b1, 1'b1, 1'b1, 5'd2, 32'h1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        eval();
        check("wrap_before", rcount, 32'hFFFF_FFFF);
        advance();
        idle(5'd2, 5'd0);
        eval();
        check("wrap_after", rcount, 32'd0);
        advance();

        // Randomized traffic focused on a few registers to create collisions.
        for (int c = 0; c < 4000; c++) begin
            set_in($urandom_range(0, 199) != 0,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7) != 0,
                   ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                   $urandom,
                   5'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                   $urandom_range(0, 1) != 0,
                   5'($urandom_range(0, 7)),
                   $urandom_range(0, 5) != 0);
            eval();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
